// File: rtl/rf_pkg.sv
// Register-file shared definitions: geometry, writeback entry layout and
// scoreboard counter type used by the writeback unit and its FIFO.
package rf_pkg;

  localparam int unsigned REG_DW   = 16;
  localparam int unsigned REG_AW   = 3;
  localparam int unsigned NUM_REGS = 8;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

  typedef logic [1:0] sb_cnt_t;

  localparam sb_cnt_t SB_MAX = 2'd3;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_unit_if.sv
// Writeback unit bus: ALU/load result handshakes, issue scoreboard port and
// register-file write port. master = result/issue source, slave = writeback unit.
interface wb_unit_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 3
);
  logic              alu_valid;
  logic              alu_ready;
  logic [AW-1:0]     alu_addr;
  logic [DW-1:0]     alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data;
  logic              hold;
  logic              issue_valid;
  logic [AW-1:0]     issue_addr;
  logic              issue_ready;
  logic              wen;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     win;
  logic [2**AW-1:0]  pending;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           hold, issue_valid, issue_addr,
    input  alu_ready, mem_ready, issue_ready, wen, waddr, win, pending
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           hold, issue_valid, issue_addr,
    output alu_ready, mem_ready, issue_ready, wen, waddr, win, pending
  );

endinterface

// File: rtl/wb_unit_fifo.sv
// wb_fifo: synchronous in-order FIFO with count-derived full/empty.
// Callers must not push when full nor pop when empty.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 19
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/wb_unit.sv
// wb_unit: arbitrates ALU/load results into an in-order FIFO, retires one per
// cycle onto the register-file write port, and tracks pending writes per register.
// Optional macro WB_BYPASS_EN: results skip the empty FIFO for 1-cycle latency.
module wb_unit
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = REG_DW,
  parameter int unsigned AW    = REG_AW
) (
  input  logic       clock,
  input  logic       reset,
  wb_unit_if.slave   bus
);
  localparam int unsigned NR = 2**AW;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        push_entry, head;
  wb_src_e       src;
  logic          full, empty, push_valid, fifo_push, pop, bypass;
  logic [CW-1:0] count;

  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] win_q, win_d;

  sb_cnt_t       cnt_q [NR];
  sb_cnt_t       cnt_d [NR];
  logic [NR-1:0] inc_v, dec_v;
  logic          issue_ok, underflow;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Load results win arbitration; readiness uses the current count only.
  always_comb begin
    bus.mem_ready = !full;
    bus.alu_ready = !full && !bus.mem_valid;
    src           = bus.mem_valid ? SRC_MEM : SRC_ALU;
    push_entry    = (src == SRC_MEM) ? entry_t'({bus.mem_addr, bus.mem_data})
                                     : entry_t'({bus.alu_addr, bus.alu_data});
    push_valid    = (bus.mem_valid && !full) || (bus.alu_valid && !full && !bus.mem_valid);
    pop           = !bus.hold && !empty;
`ifdef WB_BYPASS_EN
    bypass        = empty && !bus.hold && push_valid;
`else
    bypass        = 1'b0;
`endif
    fifo_push     = push_valid && !bypass;

    wen_d   = 1'b0;
    waddr_d = waddr_q;
    win_d   = win_q;
    if (pop) begin
      wen_d   = (head.addr != '0);
      waddr_d = head.addr;
      win_d   = head.data;
    end else if (bypass) begin
      wen_d   = (push_entry.addr != '0);
      waddr_d = push_entry.addr;
      win_d   = push_entry.data;
    end
  end

  // Decrement tracks the edge the register file commits, i.e. registered wen.
  always_comb begin
    issue_ok  = (cnt_q[bus.issue_addr] != SB_MAX);
    underflow = 1'b0;
    inc_v     = '0;
    dec_v     = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      inc_v[i] = bus.issue_valid && issue_ok && (bus.issue_addr == AW'(i)) && (i != 0);
      dec_v[i] = wen_q && (waddr_q == AW'(i));
      cnt_d[i] = cnt_q[i];
      if (inc_v[i] && !dec_v[i]) begin
        cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (dec_v[i] && !inc_v[i]) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 2'd1;
        else                underflow = 1'b1;
      end
    end
  end

  always_comb begin
    bus.pending = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      bus.pending[i] = (cnt_q[i] != '0);
    end
    bus.issue_ready = issue_ok;
    bus.wen         = wen_q;
    bus.waddr       = waddr_q;
    bus.win         = win_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      win_q   <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  a_no_unmatched_write: assert property (@(posedge clock) disable iff (reset) !underflow)
    else $error("wb_unit: write to register with no pending issue");
  a_count_bound: assert property (@(posedge clock) disable iff (reset) count <= CW'(DEPTH))
    else $error("wb_unit: FIFO count out of range");

endmodule

// File: tb/tb_wb_unit.sv
// Directed self-checking bench for wb_unit; expected latency follows WB_BYPASS_EN.
module tb_wb_unit;
  import rf_pkg::*;

`ifdef WB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  wb_unit_if #(.DW(REG_DW), .AW(REG_AW)) bus ();

  wb_unit #(.DEPTH(4), .DW(REG_DW), .AW(REG_AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_addr    = '0;
    bus.alu_data    = '0;
    bus.mem_valid   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_data    = '0;
    bus.hold        = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_addr  = '0;
  endtask

  task automatic issue(input logic [2:0] a);
    bus.issue_valid = 1'b1;
    bus.issue_addr  = a;
    tick();
    bus.issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_tests++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got=%b exp=0", bus.wen); end
    n_tests++; if (bus.waddr !== 3'd0) begin n_fail++; $display("FAIL reset_waddr got=%0d exp=0", bus.waddr); end
    n_tests++; if (bus.win !== 16'h0000) begin n_fail++; $display("FAIL reset_win got=%h exp=0000", bus.win); end
    n_tests++; if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending got=%h exp=00", bus.pending); end
    n_tests++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alu_ready got=%b exp=1", bus.alu_ready); end
    n_tests++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mem_ready got=%b exp=1", bus.mem_ready); end
    n_tests++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got=%b exp=1", bus.issue_ready); end
  endtask

  task automatic test_alu_latency();
    issue(3'd3);
    n_tests++; if (bus.pending !== 8'h08) begin n_fail++; $display("FAIL lat_pending_issue got=%h exp=08", bus.pending); end
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd3; bus.alu_data = 16'h1234;
    #1;
    n_tests++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL lat_alu_ready got=%b exp=1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    repeat (LAT - 1) tick();
    n_tests++; if (bus.wen !== 1'b1 || bus.waddr !== 3'd3 || bus.win !== 16'h1234) begin
      n_fail++; $display("FAIL lat_write got wen=%b waddr=%0d win=%h exp wen=1 waddr=3 win=1234", bus.wen, bus.waddr, bus.win);
    end
    n_tests++; if (bus.pending !== 8'h08) begin n_fail++; $display("FAIL lat_pending_during got=%h exp=08", bus.pending); end
    tick();
    n_tests++; if (bus.wen !== 1'b0 || bus.waddr !== 3'd3 || bus.win !== 16'h1234) begin
      n_fail++; $display("FAIL lat_after got wen=%b waddr=%0d win=%h exp wen=0 waddr=3 win=1234", bus.wen, bus.waddr, bus.win);
    end
    n_tests++; if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL lat_pending_clear got=%h exp=00", bus.pending); end
  endtask

  task automatic test_priority();
    logic [2:0]  ga [4];
    logic [15:0] gd [4];
    int          n = 0;
    issue(3'd5);
    issue(3'd2);
    bus.mem_valid = 1'b1; bus.mem_addr = 3'd5; bus.mem_data = 16'hBEEF;
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd2; bus.alu_data = 16'h0001;
    #1;
    n_tests++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL prio_mem_ready got=%b exp=1", bus.mem_ready); end
    n_tests++; if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL prio_alu_blocked got=%b exp=0", bus.alu_ready); end
    tick();
    if (bus.wen === 1'b1 && n < 4) begin ga[n] = bus.waddr; gd[n] = bus.win; n++; end
    bus.mem_valid = 1'b0;
    #1;
    n_tests++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL prio_alu_next got=%b exp=1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bus.wen === 1'b1 && n < 4) begin ga[n] = bus.waddr; gd[n] = bus.win; n++; end
      tick();
    end
    n_tests++; if (n !== 2) begin n_fail++; $display("FAIL prio_write_count got=%0d exp=2", n); end
    n_tests++; if (n < 1 || ga[0] !== 3'd5 || gd[0] !== 16'hBEEF) begin
      n_fail++; $display("FAIL prio_first got n=%0d addr=%0d data=%h exp addr=5 data=beef", n, ga[0], gd[0]);
    end
    n_tests++; if (n < 2 || ga[1] !== 3'd2 || gd[1] !== 16'h0001) begin
      n_fail++; $display("FAIL prio_second got n=%0d addr=%0d data=%h exp addr=2 data=0001", n, ga[1], gd[1]);
    end
    n_tests++; if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL prio_pending got=%h exp=00", bus.pending); end
  endtask

  task automatic test_hold_burst();
    for (int i = 1; i <= 4; i++) issue(3'(i));
    n_tests++; if (bus.pending !== 8'h1E) begin n_fail++; $display("FAIL hold_pending got=%h exp=1e", bus.pending); end
    bus.hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = 3'(i); bus.alu_data = 16'hA000 + 16'(i);
      #1;
      n_tests++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL hold_push%0d_ready got=%b exp=1", i, bus.alu_ready); end
      tick();
    end
    bus.alu_addr = 3'd5; bus.alu_data = 16'hDEAD;
    #1;
    n_tests++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL hold_full got alu_ready=%b mem_ready=%b exp 0 0", bus.alu_ready, bus.mem_ready);
    end
    n_tests++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL hold_wen got=%b exp=0", bus.wen); end
    bus.alu_valid = 1'b0;
    bus.hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++; if (bus.wen !== 1'b1 || bus.waddr !== 3'(i) || bus.win !== 16'hA000 + 16'(i)) begin
        n_fail++; $display("FAIL hold_drain%0d got wen=%b waddr=%0d win=%h exp wen=1 waddr=%0d win=%h",
                           i, bus.wen, bus.waddr, bus.win, i, 16'hA000 + 16'(i));
      end
    end
    tick();
    n_tests++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL hold_drain_end got=%b exp=0", bus.wen); end
    n_tests++; if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL hold_pending_clear got=%h exp=00", bus.pending); end
  endtask

  task automatic test_r0();
    int seen = 0;
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd0; bus.alu_data = 16'hFFFF;
    tick();
    bus.alu_valid = 1'b0;
    repeat (LAT - 1) tick();
    n_tests++; if (bus.wen !== 1'b0 || bus.waddr !== 3'd0 || bus.win !== 16'hFFFF) begin
      n_fail++; $display("FAIL r0_pop got wen=%b waddr=%0d win=%h exp wen=0 waddr=0 win=ffff", bus.wen, bus.waddr, bus.win);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.wen === 1'b1) seen++;
    end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL r0_no_wen got=%0d exp=0", seen); end
    n_tests++; if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL r0_pending got=%h exp=00", bus.pending); end
  endtask

  task automatic test_scoreboard();
    issue(3'd4);
    issue(3'd4);
    n_tests++; if (bus.pending !== 8'h10) begin n_fail++; $display("FAIL sb_two_issues got=%h exp=10", bus.pending); end
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd4; bus.alu_data = 16'h0001;
    tick();
    bus.alu_data = 16'h0002;
    tick();
    bus.alu_valid = 1'b0;
    repeat (LAT - 1) tick();
    n_tests++; if (bus.wen !== 1'b1 || bus.waddr !== 3'd4 || bus.win !== 16'h0002) begin
      n_fail++; $display("FAIL sb_second_write got wen=%b waddr=%0d win=%h exp wen=1 waddr=4 win=0002", bus.wen, bus.waddr, bus.win);
    end
    n_tests++; if (bus.pending !== 8'h10) begin n_fail++; $display("FAIL sb_after_first got=%h exp=10", bus.pending); end
    tick();
    n_tests++; if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL sb_after_second got=%h exp=00", bus.pending); end
  endtask

  task automatic test_saturate();
    bus.issue_valid = 1'b1; bus.issue_addr = 3'd4;
    tick(); tick(); tick();
    n_tests++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_ready4 got=%b exp=0", bus.issue_ready); end
    tick();
    bus.issue_addr = 3'd5;
    #1;
    n_tests++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_ready5 got=%b exp=1", bus.issue_ready); end
    bus.issue_valid = 1'b0;
    bus.issue_addr = 3'd4;
    #1;
    n_tests++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_hold3 got=%b exp=0", bus.issue_ready); end
    n_tests++; if (bus.pending !== 8'h10) begin n_fail++; $display("FAIL sat_pending got=%h exp=10", bus.pending); end
  endtask

  task automatic test_reset_mid_burst();
    int seen = 0;
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd4; bus.alu_data = 16'h0007;
    tick();
    bus.alu_data = 16'h0008;
    tick();
    bus.alu_data = 16'h0009;
    tick();
    bus.alu_valid = 1'b0;
    n_tests++; if (bus.wen !== 1'b1) begin n_fail++; $display("FAIL rst_burst_active got=%b exp=1", bus.wen); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_tests++; if (bus.wen !== 1'b0 || bus.pending !== 8'h00) begin
      n_fail++; $display("FAIL rst_burst_clear got wen=%b pending=%h exp wen=0 pending=00", bus.wen, bus.pending);
    end
    n_tests++; if (bus.waddr !== 3'd0 || bus.win !== 16'h0000) begin
      n_fail++; $display("FAIL rst_burst_port got waddr=%0d win=%h exp 0 0000", bus.waddr, bus.win);
    end
    n_tests++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_burst_issue_ready got=%b exp=1", bus.issue_ready); end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.wen === 1'b1) seen++;
    end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL rst_burst_discard got=%0d exp=0", seen); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu_latency();
    test_priority();
    test_hold_burst();
    test_r0();
    test_scoreboard();
    test_saturate();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Writeback unit that drives the single write port (wen/waddr/win) of the 8x16 register file. It is the producer end of that interface.
- Accepts results from two sources over valid/ready handshakes: ALU (single-cycle) and memory load (multi-cycle).
- Queues accepted results in a small in-order FIFO and retires one per cycle.
- Keeps a per-register pending-write scoreboard that issue logic uses for hazard stalls.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2)
- DW, 16, data width
- AW, 3, register address width (2**AW registers)

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
- alu_addr  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- mem_valid  in  1  load result valid
- mem_ready  out  1  load result accepted when high with mem_valid
- mem_addr  in  AW  load destination
- mem_data  in  DW  load data
- hold  in  1  freeze retirement (write port borrowed)
- issue_valid  in  1  instruction with destination issues this cycle
- issue_addr  in  AW  its destination
- issue_ready  out  1  issue permitted (scoreboard not saturated)
- wen  out  1  register file write enable (registered)
- waddr  out  AW  write address (registered)
- win  out  DW  write data (registered)
- pending  out  2**AW  bit i = register i has an outstanding write

Behaviour:
- Reset (synchronous): FIFO emptied, wen=0, waddr=0, win=0, all scoreboard counters 0, pending=0. In-flight results are discarded.
- Ready signals (combinational):
  - mem_ready = !full.
  - alu_ready = !full && !mem_valid. Memory has fixed priority, and at most one push per cycle.
- Push: on a valid&&ready handshake, {addr,data} is written at the FIFO tail on that edge.
- Retire, on each edge:
  - If !hold && !empty: pop the head; wen<=(head.addr!=0), waddr<=head.addr, win<=head.data.
  - Otherwise wen<=0, and waddr/win hold their previous values.
  - An entry with addr 0 is popped but never asserts wen, since r0 is hardwired.
- Latency: handshake at edge N gives wen high in the cycle after edge N+1 (2 cycles). Order is strictly the order of acceptance.
- Simultaneous push and pop: count is unchanged. When full, a pop frees no slot in the same cycle, because ready is computed from the current count.
- Pointers are log2(DEPTH) bits and wrap naturally. full/empty are derived from a separate count register of width log2(DEPTH)+1.
- Scoreboard: one 2-bit counter per register i.
  - Increment on issue_valid&&issue_ready&&issue_addr==i.
  - Decrement on any edge where wen==1 && waddr==i, i.e. the edge at which the register file commits the write.
  - Increment and decrement in the same edge leave the counter unchanged.
  - Register 0 never counts, and its counter stays 0.
  - issue_ready = (counter[issue_addr] != 3).
  - pending[i] = (counter[i] != 0).
  - A decrement at 0 (unmatched write) saturates at 0. This is flagged in simulation as an error.
- hold asserted mid-burst: wen drops on the next edge, the FIFO keeps its contents, and draining resumes in order once hold falls.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when the FIFO is empty, !hold, and a handshake occurs, the result loads straight into wen/waddr/win on that edge without entering the FIFO. Latency is 1 cycle. Ordering is still preserved, because bypass happens only when the FIFO is empty.
- Undefined: every result passes through the FIFO, with the fixed 2-cycle latency.

Decomposition:
- Shared package `rf_pkg`:
  - constants REG_DW=16, REG_AW=3, NUM_REGS=8
  - typedef wb_entry_t {addr, data}
  - typedef sb_cnt_t (2-bit)
- One sub-module, `wb_fifo`: parameterised sync FIFO providing push, pop, head, full, empty and count. The scoreboard and arbitration stay in the top module.

Test Plan:
- Reset, then idle -> wen=0, pending=8'h00, alu_ready=mem_ready=issue_ready=1.
- ALU push addr=3 data=16'h1234, hold=0 -> wen=1, waddr=3, win=16'h1234 exactly 2 cycles after the handshake (1 cycle with WB_BYPASS_EN).
- Same cycle mem(5,16'hBEEF) and alu(2,16'h0001) -> mem_ready=1, alu_ready=0; ALU accepted next cycle; writes seen in order r5 then r2.
- hold=1, push 4 ALU results (r1..r4) -> 5th cycle alu_ready=0 and mem_ready=0; release hold -> 4 consecutive wen cycles r1,r2,r3,r4 with no gaps.
- Push addr=0 data=16'hFFFF -> FIFO empties, wen never asserts.
- issue r4 twice -> pending[4]=1. First write r4 keeps pending[4]=1; second write clears it. Three issues without writes -> issue_ready=0 for issue_addr=4. Reset mid-burst -> pending=0 and wen=0 on the next cycle.
